// File: rtl/serial_tx_arbiter.sv
// Round-robin arbiter that grants one of N_REQ byte sources and shifts the byte out as an 8N1 frame.
// Grant, ack, busy and tx_out are all registered; back-to-back frames re-arbitrate on the last stop-bit cycle.
module serial_tx_arbiter #(
  parameter int N_REQ        = 4,
  parameter int CLKS_PER_BIT = 16
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [N_REQ-1:0]   req,
  input  logic [8*N_REQ-1:0] data,
  output logic [N_REQ-1:0]   ack,
  output logic               busy,
  output logic               tx_out
);

  localparam int GW = $clog2(N_REQ);
  localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BIT_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t          state;
  logic [BW-1:0]   baud_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;
  logic [GW-1:0]   last_grant;

  logic            any_req;
  logic            bit_end;
  logic            launch;
  logic            hi_found;
  logic [GW-1:0]   hi_idx;
  logic [GW-1:0]   lo_idx;
  logic [GW-1:0]   grant_idx;
  logic [7:0]      grant_byte;

  assign any_req = |req;
  assign bit_end = (baud_cnt == BIT_LAST);
  assign launch  = any_req && ((state == IDLE) || (state == STOP && bit_end));

  // Descending scan leaves the lowest requester above last_grant in hi_idx,
  // and the lowest requester overall in lo_idx for the wrap-around case.
  always_comb begin
    hi_found   = 1'b0;
    hi_idx     = '0;
    lo_idx     = '0;
    grant_byte = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        lo_idx = GW'(i);
        if (i > int'(last_grant)) begin
          hi_found = 1'b1;
          hi_idx   = GW'(i);
        end
      end
    end
    grant_idx = hi_found ? hi_idx : lo_idx;
    for (int i = 0; i < N_REQ; i++) begin
      if (GW'(i) == grant_idx) grant_byte = data[8*i +: 8];
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      baud_cnt   <= '0;
      bit_idx    <= '0;
      shift      <= '0;
      last_grant <= GW'(N_REQ - 1);
      ack        <= '0;
      busy       <= 1'b0;
      tx_out     <= 1'b1;
    end else begin
      ack <= '0;
      if (launch) begin
        state      <= START;
        last_grant <= grant_idx;
        shift      <= grant_byte;
        ack        <= N_REQ'(1) << grant_idx;
        baud_cnt   <= '0;
        bit_idx    <= '0;
        busy       <= 1'b1;
        tx_out     <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            busy   <= 1'b0;
            tx_out <= 1'b1;
          end
          START: begin
            if (bit_end) begin
              state    <= DATA;
              baud_cnt <= '0;
              bit_idx  <= '0;
              tx_out   <= shift[0];
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          DATA: begin
            if (bit_end) begin
              baud_cnt <= '0;
              if (bit_idx == 3'd7) begin
                state  <= STOP;
                tx_out <= 1'b1;
              end else begin
                // tx_out takes the bit that becomes shift[0] after this shift
                shift   <= shift >> 1;
                bit_idx <= bit_idx + 3'd1;
                tx_out  <= shift[1];
              end
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          STOP: begin
            if (bit_end) begin
              state    <= IDLE;
              baud_cnt <= '0;
              busy     <= 1'b0;
              tx_out   <= 1'b1;
            end else begin
              baud_cnt <= baud_cnt + 1'b1;
            end
          end
          default: begin
            state  <= IDLE;
            busy   <= 1'b0;
            tx_out <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_serial_tx_arbiter.sv
// Bench for serial_tx_arbiter: a scoreboard of expected grants is checked against acks and the serial line.
module tb_serial_tx_arbiter;

  localparam int N    = 4;
  localparam int CPB  = 4;
  localparam int CPB2 = 2;

  logic           clock = 1'b0;
  logic           reset;
  logic [N-1:0]   req;
  logic [8*N-1:0] data;
  logic [N-1:0]   ack;
  logic           busy;
  logic           tx_out;

  logic [1:0]     req2;
  logic [15:0]    data2;
  logic [1:0]     ack2;
  logic           busy2;
  logic           tx2;

  always #5 clock = ~clock;

  serial_tx_arbiter #(.N_REQ(N), .CLKS_PER_BIT(CPB)) dut (
    .clock(clock), .reset(reset), .req(req), .data(data),
    .ack(ack), .busy(busy), .tx_out(tx_out)
  );

  serial_tx_arbiter #(.N_REQ(2), .CLKS_PER_BIT(CPB2)) dut_min (
    .clock(clock), .reset(reset), .req(req2), .data(data2),
    .ack(ack2), .busy(busy2), .tx_out(tx2)
  );

  typedef struct {
    int         idx;
    logic [7:0] val;
  } exp_t;

  exp_t       sb[$];
  exp_t       sb2[$];
  exp_t       mon_e;
  int         checks = 0;
  int         errors = 0;
  logic [N-1:0] keep = '0;
  bit         mon_act = 1'b0;
  int         mon_off = 0;
  logic [7:0] mon_byte = '0;

  function automatic logic exp_bit(input logic [7:0] b, input int off, input int cpb);
    int n;
    n = off / cpb;
    if (n == 0) return 1'b0;
    else if (n <= 8) return b[n-1];
    else return 1'b1;
  endfunction

  // Frame monitor: each ack pops one expected grant, then every cycle of the frame is compared.
  always @(negedge clock) begin
    if (reset) begin
      mon_act = 1'b0;
    end else begin
      if (ack !== '0) begin
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL ack_unexpected got %b want 0000", ack);
        end else begin
          mon_e = sb.pop_front();
          if (mon_act || ack !== (N'(1) << mon_e.idx)) begin
            errors++;
            $display("FAIL ack_grant got %b at offset %0d want %b after full frame",
                     ack, mon_act ? mon_off : 10*CPB, N'(1) << mon_e.idx);
          end
          mon_byte = mon_e.val;
          mon_act  = 1'b1;
          mon_off  = 0;
        end
      end
      checks++;
      if (mon_act) begin
        if (tx_out !== exp_bit(mon_byte, mon_off, CPB) || busy !== 1'b1) begin
          errors++;
          $display("FAIL frame_bit offset %0d got tx=%b busy=%b want tx=%b busy=1",
                   mon_off, tx_out, busy, exp_bit(mon_byte, mon_off, CPB));
        end
        mon_off++;
        if (mon_off == 10*CPB) mon_act = 1'b0;
      end else if (tx_out !== 1'b1 || busy !== 1'b0) begin
        errors++;
        $display("FAIL idle_line got tx=%b busy=%b want tx=1 busy=0", tx_out, busy);
      end
    end
  end

  // One cycle; requesters drop req on their ack unless held by keep.
  task automatic step();
    @(negedge clock);
    for (int i = 0; i < N; i++) begin
      if (ack[i] && !keep[i]) req[i] = 1'b0;
    end
  endtask

  task automatic wait_idle(output int cnt);
    bit done;
    cnt  = 0;
    done = 1'b0;
    for (int n = 0; n < 2000 && !done; n++) begin
      step();
      if (busy) cnt++;
      else if (cnt > 0 && req == '0) done = 1'b1;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL idle_timeout got busy_cycles %0d want return to idle", cnt);
    end
  endtask

  task automatic wait_ack(input int i);
    bit seen;
    seen = 1'b0;
    for (int n = 0; n < 50 && !seen; n++) begin
      step();
      if (ack[i]) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL ack_timeout requester %0d got no ack want ack", i);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    req   = '0;
    data  = '0;
    req2  = '0;
    data2 = '0;
    #1;
    checks++;
    if (tx_out !== 1'b1) begin errors++; $display("FAIL reset_tx got %b want 1", tx_out); end
    checks++;
    if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++;
    if (ack !== '0) begin errors++; $display("FAIL reset_ack got %b want 0000", ack); end
    repeat (2) @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic test_single();
    int cnt;
    sb.push_back('{0, 8'hA5});
    data[7:0] = 8'hA5;
    req = 4'b0001;
    wait_idle(cnt);
    checks++;
    if (cnt != 10*CPB) begin errors++; $display("FAIL single_busy got %0d want %0d", cnt, 10*CPB); end
  endtask

  task automatic test_back_to_back();
    int cnt;
    @(negedge clock) reset = 1'b1;
    @(negedge clock) reset = 1'b0;
    for (int i = 0; i < N; i++) begin
      data[8*i +: 8] = 8'(8'h11 * (i + 1));
      sb.push_back('{i, 8'(8'h11 * (i + 1))});
    end
    req = 4'b1111;
    wait_idle(cnt);
    checks++;
    if (cnt != 4*10*CPB) begin errors++; $display("FAIL b2b_busy got %0d want %0d", cnt, 4*10*CPB); end
  endtask

  task automatic test_fairness();
    int cnt;
    int n0;
    int last;
    bit consec;
    sb.push_back('{2, 8'h5C});
    data[23:16] = 8'h5C;
    req = 4'b0100;
    wait_idle(cnt);
    data[7:0]   = 8'h0F;
    data[23:16] = 8'hF0;
    sb.push_back('{0, 8'h0F});
    sb.push_back('{2, 8'hF0});
    sb.push_back('{0, 8'h0F});
    keep   = 4'b0001;
    req    = 4'b0101;
    n0     = 0;
    last   = 2;
    consec = 1'b0;
    for (int n = 0; n < 500 && n0 < 2; n++) begin
      step();
      if (ack[0]) begin
        if (last == 0) consec = 1'b1;
        last = 0;
        n0++;
        if (n0 == 2) begin
          keep   = '0;
          req[0] = 1'b0;
        end
      end else if (ack[2]) begin
        last = 2;
      end
    end
    checks++;
    if (n0 != 2 || consec) begin
      errors++;
      $display("FAIL fairness got grants0=%0d consecutive=%0d want 2 and 0", n0, consec);
    end
    wait_idle(cnt);
  endtask

  task automatic test_reset_mid();
    int cnt;
    sb.push_back('{0, 8'h52});
    data[7:0] = 8'h52;
    req = 4'b0001;
    wait_ack(0);
    repeat (4*CPB + 1) step();
    #2 reset = 1'b1;
    #1;
    checks++;
    if (tx_out !== 1'b1 || busy !== 1'b0 || ack !== '0) begin
      errors++;
      $display("FAIL reset_mid got tx=%b busy=%b ack=%b want 1 0 0000", tx_out, busy, ack);
    end
    data[15:8] = 8'h96;
    sb.push_back('{1, 8'h96});
    req = 4'b0010;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    wait_idle(cnt);
    checks++;
    if (cnt != 10*CPB) begin errors++; $display("FAIL reset_mid_frame got %0d want %0d", cnt, 10*CPB); end
  endtask

  task automatic test_withdrawn();
    bit seen3;
    sb.push_back('{0, 8'h3C});
    data[7:0]   = 8'h3C;
    data[31:24] = 8'h77;
    req = 4'b0001;
    wait_ack(0);
    repeat (5*CPB) step();
    req[3] = 1'b1;
    repeat (3*CPB) step();
    req[3] = 1'b0;
    seen3 = 1'b0;
    for (int n = 0; n < 20; n++) begin
      step();
      if (ack[3]) seen3 = 1'b1;
    end
    checks++;
    if (seen3 || busy !== 1'b0) begin
      errors++;
      $display("FAIL withdrawn got ack3=%0d busy=%b want 0 0", seen3, busy);
    end
  endtask

  task automatic test_min_period();
    exp_t e;
    bit   seen;
    sb2.push_back('{0, 8'hFF});
    data2[7:0] = 8'hFF;
    req2 = 2'b01;
    seen = 1'b0;
    for (int n = 0; n < 10 && !seen; n++) begin
      @(negedge clock);
      if (ack2 !== '0) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL min_ack_timeout got no ack want ack");
    end else begin
      e = sb2.pop_front();
      req2 = 2'b00;
      checks++;
      if (ack2 !== (2'(1) << e.idx)) begin
        errors++;
        $display("FAIL min_ack got %b want %b", ack2, 2'(1) << e.idx);
      end
      for (int off = 0; off < 10*CPB2; off++) begin
        checks++;
        if (tx2 !== exp_bit(e.val, off, CPB2) || busy2 !== 1'b1) begin
          errors++;
          $display("FAIL min_bit offset %0d got tx=%b busy=%b want tx=%b busy=1",
                   off, tx2, busy2, exp_bit(e.val, off, CPB2));
        end
        @(negedge clock);
      end
      checks++;
      if (tx2 !== 1'b1 || busy2 !== 1'b0) begin
        errors++;
        $display("FAIL min_end got tx=%b busy=%b want 1 0", tx2, busy2);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout got no finish want finish");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_fairness();
    test_reset_mid();
    test_withdrawn();
    test_min_period();
    checks++;
    if (sb.size() != 0 || sb2.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_left got %0d/%0d entries want 0", sb.size(), sb2.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
